snake_master_ctrl: RTL and testbench
====================================

# snake_master_ctrl

Top-level game sequencer for the snake design. Owns the master game state (IDLE/PLAY/WIN, plus LOSE when timeout is compiled in) consumed by the snake datapath, the navigation FSM and the VGA colour path. Counts targets eaten. Runs a request/acknowledge handshake with the target generator so a fresh target is produced at game start and after every catch.

## Interface
- WIN_SCORE, 10: targets to catch to reach WIN; legal 1..2^SCORE_W-1
- SCORE_W, 4: width of SCORE
- HOLD_CYCLES, 200_000_000: cycles spent in WIN/LOSE before automatic return to IDLE (2 s at 100 MHz)
- TIMEOUT_CYCLES, 1_000_000_000: max cycles between catches in PLAY (only with timeout compiled in)
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-high reset
- BTNU, BTND, BTNL, BTNR  in  1 each  raw push buttons, asynchronous to CLK
- REACHED_TARGET  in  1  one-cycle pulse from snake datapath when head hits target
- TARGET_ACK  in  1  target generator has latched a new target
- MASTER_STATE  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
- SCORE  out  SCORE_W  targets caught this game
- NEW_TARGET_REQ  out  1  request a new target; level, held until acknowledged

## Operation
- Buttons: each passes a 2-flop synchroniser, then rising-edge detect; `any_press` = OR of the four edge strobes.
- IDLE: `any_press` -> PLAY; SCORE cleared to 0 on the same edge; NEW_TARGET_REQ set.
- PLAY: REACHED_TARGET increments SCORE and sets NEW_TARGET_REQ. If SCORE+1 == WIN_SCORE on that pulse -> WIN (SCORE shows WIN_SCORE). Buttons are ignored for state purposes.
- WIN / LOSE: hold counter counts 0..HOLD_CYCLES-1, then -> IDLE. Buttons are ignored. SCORE is frozen and is not cleared until the next IDLE->PLAY.
- REACHED_TARGET outside PLAY: ignored.
- Handshake: next NEW_TARGET_REQ = set_event OR (NEW_TARGET_REQ AND NOT TARGET_ACK).
  - A set_event while a request is already outstanding does not queue a second request.
  - A set_event in the same cycle as TARGET_ACK keeps the request high, which starts a new request.
  - The request is never dropped on a state change. An outstanding request completes normally after WIN.
- SCORE arithmetic: unsigned, SCORE_W bits, never wraps. The WIN transition occurs before overflow.

## Timing
- Reset values: MASTER_STATE=00, SCORE=0, NEW_TARGET_REQ=0. All synchroniser, edge, hold and timeout registers are 0.
- RESET asserted mid-game: all outputs go to reset values immediately (asynchronous), regardless of state or an outstanding request.
- All outputs are registered; no combinational path from inputs to outputs.
- Button latency: button high at sampling edge N -> MASTER_STATE=PLAY after edge N+2. A button held high produces exactly one press.
- REACHED_TARGET high at edge N -> SCORE, NEW_TARGET_REQ and any WIN transition update at edge N.
- TARGET_ACK high at edge N with no new event -> NEW_TARGET_REQ low after edge N.
- WIN/LOSE entered at edge N -> IDLE after edge N+HOLD_CYCLES.

## Configuration
- Macro `SNAKE_TIMEOUT_EN`.
- Defined:
  - A timeout counter runs in PLAY and is cleared on entry to PLAY and on each REACHED_TARGET.
  - When it reaches TIMEOUT_CYCLES-1 -> LOSE (11).
  - If REACHED_TARGET coincides with expiry, the catch wins: score increments and the counter clears, no LOSE.
  - LOSE behaves like WIN (hold, then IDLE).
- Undefined: no timeout counter is built, and state 11 is unreachable.

## Structure
- Shared package `snake_pkg`: master state encodings (IDLE/PLAY/WIN/LOSE), direction encodings, colour constants, grid limits (MaxX=159, MaxY=119). These are shared with the snake datapath, navigation FSM and VGA path.
- One sub-module, `btn_sync_edge`: 2-flop synchroniser plus rising-edge detect, instantiated four times.
- Everything else (state register, score, hold/timeout counters, request flop) lives in snake_master_ctrl.

## Test plan
- Reset, then pulse BTNL high at edge 10 -> MASTER_STATE=01 after edge 12, SCORE=0, NEW_TARGET_REQ=1. Assert TARGET_ACK at edge 15 -> REQ=0 after edge 15.
- WIN_SCORE=3, send 3 REACHED_TARGET pulses, each acked -> SCORE 1,2,3. State 10 on the third pulse edge. With HOLD_CYCLES=8, IDLE 8 cycles later and SCORE still 3.
- REACHED_TARGET on the same edge as TARGET_ACK -> REQ stays 1. Second pulse while REQ is already 1 -> REQ stays 1, SCORE +1, only one ACK needed.
- BTNR held high for 100 cycles in IDLE -> a single IDLE->PLAY. Button presses in PLAY and WIN -> no state change. REACHED_TARGET in IDLE -> SCORE unchanged.
- RESET asserted mid-PLAY with SCORE=2 and REQ=1 -> all outputs reset with no clock edge.
- With `SNAKE_TIMEOUT_EN` and TIMEOUT_CYCLES=16: no catch -> state 11 after 16 cycles in PLAY. Catch on the expiry edge -> remain in PLAY, SCORE +1.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: encodings and constants shared by the snake controller, datapath, navigation FSM and VGA path.
package snake_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOSE = 2'b11
   } master_state_e;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
   localparam logic [11:0] COLOUR_BG     = 12'h000;
   localparam logic [11:0] COLOUR_SNAKE  = 12'h0F0;
   localparam logic [11:0] COLOUR_TARGET = 12'hF00;
   localparam logic [11:0] COLOUR_WIN    = 12'h0FF;
   localparam logic [11:0] COLOUR_LOSE   = 12'hF0F;
   localparam int MAX_X = 159;
   localparam int MAX_Y = 119;
endpackage

// File: rtl/snake_master_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser for an asynchronous button followed by a rising-edge strobe.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);
   logic [2:0] sync;
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else     sync <= {sync[1:0], btn};
   assign rise = sync[1] & ~sync[2];
endmodule

// File: rtl/snake_master_ctrl.sv
// snake_master_ctrl: game sequencer (IDLE/PLAY/WIN[/LOSE]), score and target request handshake.
// Define SNAKE_TIMEOUT_EN to build the PLAY timeout that leads to LOSE.
module snake_master_ctrl
   import snake_pkg::*;
#(
   parameter int WIN_SCORE      = 10,
   parameter int SCORE_W        = 4,
   parameter int HOLD_CYCLES    = 200_000_000,
   parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               BTNU,
   input  logic               BTND,
   input  logic               BTNL,
   input  logic               BTNR,
   input  logic               REACHED_TARGET,
   input  logic               TARGET_ACK,
   output logic [1:0]         MASTER_STATE,
   output logic [SCORE_W-1:0] SCORE,
   output logic               NEW_TARGET_REQ
);
   // one width covers both the hold and timeout counters
   localparam int CW = $clog2((HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES) + 1);
   master_state_e state, state_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [CW-1:0] hold_cnt, hold_nxt;
   logic [3:0] btns, rise;
   logic any_press, set_req, req_nxt;
`ifdef SNAKE_TIMEOUT_EN
   logic [CW-1:0] to_cnt, to_nxt;
`endif
   assign btns = {BTNU, BTND, BTNL, BTNR};
   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_sync_edge u_btn (.clk(CLK), .rst(RESET), .btn(btns[i]), .rise(rise[i]));
   end
   assign any_press = |rise;
   assign MASTER_STATE = state;
   always_comb begin
      state_nxt = state;
      score_nxt = SCORE;
      hold_nxt  = '0;
      set_req   = 1'b0;
`ifdef SNAKE_TIMEOUT_EN
      to_nxt    = '0;
`endif
      case (state)
         ST_IDLE: if (any_press) begin
            state_nxt = ST_PLAY;
            score_nxt = '0;
            set_req   = 1'b1;
         end
         ST_PLAY: begin
            // a catch on the expiry cycle takes priority over the timeout
            if (REACHED_TARGET) begin
               score_nxt = SCORE + 1'b1;
               set_req   = 1'b1;
               if (SCORE == SCORE_W'(WIN_SCORE - 1)) state_nxt = ST_WIN;
            end
`ifdef SNAKE_TIMEOUT_EN
            else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) state_nxt = ST_LOSE;
            else to_nxt = to_cnt + 1'b1;
`endif
         end
         default: if (hold_cnt == CW'(HOLD_CYCLES - 1)) state_nxt = ST_IDLE;
                  else hold_nxt = hold_cnt + 1'b1;
      endcase
      req_nxt = set_req | (NEW_TARGET_REQ & ~TARGET_ACK);
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state          <= ST_IDLE;
         SCORE          <= '0;
         NEW_TARGET_REQ <= 1'b0;
         hold_cnt       <= '0;
`ifdef SNAKE_TIMEOUT_EN
         to_cnt         <= '0;
`endif
      end else begin
         state          <= state_nxt;
         SCORE          <= score_nxt;
         NEW_TARGET_REQ <= req_nxt;
         hold_cnt       <= hold_nxt;
`ifdef SNAKE_TIMEOUT_EN
         to_cnt         <= to_nxt;
`endif
      end
endmodule

// File: tb/tb_snake_master_ctrl.sv
// tb_snake_master_ctrl: table-driven, hand-written and randomized checks against a game-level model.
module tb_snake_master_ctrl;
   localparam int WIN = 3, HOLD = 8, TO = 16;
   logic CLK = 0, RESET = 0;
   logic BTNU = 0, BTND = 0, BTNL = 0, BTNR = 0, REACHED_TARGET = 0, TARGET_ACK = 0;
   logic [1:0] MASTER_STATE;
   logic [3:0] SCORE;
   logic NEW_TARGET_REQ;
   int checks = 0, failures = 0;
   always #5 CLK = ~CLK;
   snake_master_ctrl #(.WIN_SCORE(WIN), .SCORE_W(4), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RESET(RESET), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
      .REACHED_TARGET(REACHED_TARGET), .TARGET_ACK(TARGET_ACK),
      .MASTER_STATE(MASTER_STATE), .SCORE(SCORE), .NEW_TARGET_REQ(NEW_TARGET_REQ));
   // game-level model: edge index t, entry times instead of counters
   int m_state, m_score, m_req, t, enter_t;
`ifdef SNAKE_TIMEOUT_EN
   int clr_t;
`endif
   logic [3:0] hist [4];
   task automatic m_reset();
      m_state = 0; m_score = 0; m_req = 0; t = 0; enter_t = 0;
`ifdef SNAKE_TIMEOUT_EN
      clr_t = 0;
`endif
      for (int i = 0; i < 4; i++) hist[i] = '0;
   endtask
   task automatic m_edge();
      logic [3:0] b;
      bit press, set;
      b = {BTNU, BTND, BTNL, BTNR};
      press = 0; set = 0; t++;
      for (int i = 0; i < 4; i++) begin
         hist[i] = {hist[i][2:0], b[i]};
         if (hist[i][2] && !hist[i][3]) press = 1;
      end
      if (m_state == 0) begin
         if (press) begin
            m_state = 1; m_score = 0; set = 1;
`ifdef SNAKE_TIMEOUT_EN
            clr_t = t;
`endif
         end
      end else if (m_state == 1) begin
         if (REACHED_TARGET) begin
            m_score++; set = 1;
`ifdef SNAKE_TIMEOUT_EN
            clr_t = t;
`endif
            if (m_score == WIN) begin m_state = 2; enter_t = t; end
         end
`ifdef SNAKE_TIMEOUT_EN
         else if (t - clr_t == TO) begin m_state = 3; enter_t = t; end
`endif
      end else if (t - enter_t == HOLD) m_state = 0;
      m_req = (set || (m_req && !TARGET_ACK)) ? 1 : 0;
   endtask
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   task automatic cmp_model(string n);
      chk({n, "_state"}, MASTER_STATE, m_state);
      chk({n, "_score"}, SCORE, m_score);
      chk({n, "_req"}, NEW_TARGET_REQ, m_req);
   endtask
   task automatic tick();
      @(posedge CLK);
      m_edge();
      #1;
   endtask
   task automatic do_reset();
      @(negedge CLK);
      RESET = 1;
      #1;
      chk("rst_state", MASTER_STATE, 0);
      chk("rst_score", SCORE, 0);
      chk("rst_req", NEW_TARGET_REQ, 0);
      m_reset();
      {BTNU, BTND, BTNL, BTNR, REACHED_TARGET, TARGET_ACK} = '0;
      @(posedge CLK);
      #1 RESET = 0;
   endtask
   typedef struct {logic [3:0] btn; bit r, ack; int st, sc, rq;} vec_t;
   vec_t tv [30];
   task automatic setv(int e, logic [3:0] btn, bit r, bit ack, int st, int sc, int rq);
      tv[e-1] = '{btn, r, ack, st, sc, rq};
   endtask
   initial begin
      int n, prev;
      // rows are edges 1..30 after reset release; button order {U,D,L,R}
      for (int e = 1; e <= 30; e++) setv(e, 4'b0, 0, 0, 0, 0, 0);
      setv(10, 4'b0010, 0, 0, 0, 0, 0);
      for (int e = 12; e <= 14; e++) setv(e, 4'b0, 0, 0, 1, 0, 1);
      setv(13, 4'b0100, 0, 0, 1, 0, 1);
      setv(15, 4'b0, 0, 1, 1, 0, 0);
      setv(16, 4'b0, 1, 0, 1, 1, 1);
      setv(17, 4'b0, 0, 0, 1, 1, 1);
      setv(18, 4'b0, 1, 0, 1, 2, 1);
      setv(19, 4'b0, 1, 1, 2, 3, 1);
      setv(20, 4'b0, 0, 1, 2, 3, 0);
      for (int e = 21; e <= 26; e++) setv(e, 4'b0, 0, 0, 2, 3, 0);
      setv(21, 4'b1000, 0, 0, 2, 3, 0);
      for (int e = 27; e <= 30; e++) setv(e, 4'b0, 0, 0, 0, 3, 0);
      setv(28, 4'b0, 1, 0, 0, 3, 0);
      do_reset();
      for (int i = 0; i < 30; i++) begin
         {BTNU, BTND, BTNL, BTNR} = tv[i].btn;
         REACHED_TARGET = tv[i].r;
         TARGET_ACK = tv[i].ack;
         tick();
         chk($sformatf("tv%0d_state", i + 1), MASTER_STATE, tv[i].st);
         chk($sformatf("tv%0d_score", i + 1), SCORE, tv[i].sc);
         chk($sformatf("tv%0d_req", i + 1), NEW_TARGET_REQ, tv[i].rq);
         cmp_model($sformatf("tv%0d_model", i + 1));
      end
      {BTNU, BTND, BTNL, BTNR, REACHED_TARGET, TARGET_ACK} = '0;
      // held button: one press only
      BTNR = 1; n = 0;
      for (int i = 0; i < 100; i++) begin
         prev = MASTER_STATE;
         tick();
         cmp_model("held");
         if (prev != 1 && MASTER_STATE == 1) n++;
      end
      BTNR = 0;
      chk("held_btn_presses", n, 1);
      // async reset mid-PLAY with score 2 and an outstanding request
      do_reset();
      BTNL = 1; tick(); BTNL = 0; tick(); tick();
      REACHED_TARGET = 1; tick(); tick(); REACHED_TARGET = 0;
      chk("pre_rst_state", MASTER_STATE, 1);
      chk("pre_rst_score", SCORE, 2);
      chk("pre_rst_req", NEW_TARGET_REQ, 1);
      do_reset();
`ifdef SNAKE_TIMEOUT_EN
      BTNL = 1; tick(); BTNL = 0; tick(); tick();
      chk("to_enter_play", MASTER_STATE, 1);
      for (int i = 0; i < 15; i++) tick();
      chk("to_pre_expiry", MASTER_STATE, 1);
      tick();
      chk("to_lose", MASTER_STATE, 3);
      for (int i = 0; i < HOLD; i++) tick();
      chk("lose_to_idle", MASTER_STATE, 0);
      BTNL = 1; tick(); BTNL = 0; tick(); tick();
      for (int i = 0; i < 15; i++) tick();
      REACHED_TARGET = 1; tick(); REACHED_TARGET = 0;
      chk("expiry_catch_state", MASTER_STATE, 1);
      chk("expiry_catch_score", SCORE, 1);
      for (int i = 0; i < 15; i++) tick();
      chk("to2_pre_expiry", MASTER_STATE, 1);
      tick();
      chk("to2_lose", MASTER_STATE, 3);
      do_reset();
`endif
      for (int i = 0; i < 3000; i++) begin
         {BTNU, BTND, BTNL, BTNR} = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
         REACHED_TARGET = ($urandom_range(0, 3) == 0);
         TARGET_ACK = ($urandom_range(0, 2) == 0);
         tick();
         cmp_model("rnd");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
